// File: rtl/kmac_pkg.sv
// Shared KMAC front-end types and helpers: encoder FSM states and the
// left_encode/right_encode value-byte count.
package kmac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_N,
    HDR_VAL,
    BODY,
    DONE
  } enc_state_t;

  // Number of bytes needed to hold the value, never fewer than one (value 0 encodes as one byte).
  function automatic int unsigned le_num_bytes(input logic [31:0] bits);
    int unsigned n;
    n = 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (bits[i]) n = i / 8 + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/kmac_encode_string_stream_if.sv
// Control and byte-stream handshake bundle for the encode_string block.
interface kmac_encode_string_stream_if #(
  parameter int unsigned LEN_W = 9
);
  logic             start;
  logic [LEN_W-1:0] str_len;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;

  modport master (
    output start, str_len, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    input  start, str_len, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/kmac_left_encode.sv
// Combinational left_encode core: value-byte count n and the value as a
// big-endian byte array (be_o[0] is the most significant byte).
module kmac_left_encode
  import kmac_pkg::*;
#(
  parameter int unsigned BITS_W  = 12,
  parameter int unsigned HDR_MAX = (BITS_W + 7) / 8
) (
  input  logic [BITS_W-1:0] bits_i,
  output logic [7:0]        n_o,
  output logic [7:0]        be_o [HDR_MAX]
);
  localparam int unsigned PAD_W = 8 * HDR_MAX;

  logic [PAD_W-1:0] padded;

  assign padded = PAD_W'(bits_i);
  assign n_o    = 8'(le_num_bytes(32'(bits_i)));

  always_comb begin
    for (int unsigned i = 0; i < HDR_MAX; i++) begin
      be_o[i] = padded[8*(HDR_MAX-1-i) +: 8];
    end
  end
endmodule

// File: rtl/kmac_encode_string_stream.sv
// Streaming encode_string: emits left_encode(8*L) followed by the L string
// bytes, which are passed through combinationally with no buffering.
module kmac_encode_string_stream
  import kmac_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned BITS_W  = LEN_W + 3,
  parameter int unsigned HDR_MAX = (BITS_W + 7) / 8
) (
  input logic                        clk,
  input logic                        rst,
  kmac_encode_string_stream_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(HDR_MAX) + 1;

  enc_state_t        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_clamped;
  logic [7:0]        n;
  logic [7:0]        be [HDR_MAX];
  logic [7:0]        hdr_byte;
  logic              out_hs;

  kmac_left_encode #(
    .BITS_W (BITS_W),
    .HDR_MAX(HDR_MAX)
  ) u_left_encode (
    .bits_i(bits_q),
    .n_o   (n),
    .be_o  (be)
  );

  assign len_clamped = (bus.str_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.str_len;
  assign out_hs      = bus.out_valid && bus.out_ready;

  // idx counts value bytes down from n-1; be[] is MSB-first over HDR_MAX bytes.
  always_comb begin
    hdr_byte = '0;
    for (int unsigned i = 0; i < HDR_MAX; i++) begin
      if (idx_q == IDX_W'(HDR_MAX - 1 - i)) hdr_byte = be[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    bits_d        = bits_q;
    idx_d         = idx_q;
    bus.out_data  = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;

    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          len_d   = len_clamped;
          bits_d  = BITS_W'({len_clamped, 3'b000});
          cnt_d   = '0;
          state_d = HDR_N;
        end
      end
      HDR_N: begin
        bus.out_valid = 1'b1;
        bus.out_data  = n;
        if (out_hs) begin
          idx_d   = IDX_W'(n - 8'd1);
          state_d = HDR_VAL;
        end
      end
      HDR_VAL: begin
        bus.out_valid = 1'b1;
        bus.out_data  = hdr_byte;
        bus.out_last  = (len_q == '0) && (idx_q == '0);
        if (out_hs) begin
          if (idx_q == '0) state_d = (len_q != '0) ? BODY : DONE;
          else             idx_d   = idx_q - IDX_W'(1);
        end
      end
      BODY: begin
        bus.out_valid = bus.in_valid;
        bus.out_data  = bus.in_data;
        bus.in_ready  = bus.out_ready;
        bus.out_last  = (cnt_q == len_q - LEN_W'(1));
        if (out_hs) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_kmac_encode_string_stream.sv
// Scoreboard bench for kmac_encode_string_stream: stimulus queues expected
// {last,data} bytes, a negedge monitor pops and compares each output handshake.
module tb_kmac_encode_string_stream;
  localparam int unsigned MAX_LEN = 256;
  localparam int unsigned LEN_W   = 9;

  logic clk = 1'b0;
  logic rst;

  kmac_encode_string_stream_if #(.LEN_W(LEN_W)) bus ();

  kmac_encode_string_stream #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned start_cyc = 0;
  logic [8:0]  exp_q [$];
  logic [7:0]  body [$];
  bit          stall_mode = 1'b0;
  bit          in_ready_seen = 1'b0;
  bit          prev_v = 1'b0, prev_r = 1'b0, prev_done = 1'b0;
  logic [7:0]  prev_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e[7:0]));
          check("out_last", 32'(bus.out_last), 32'(e[8]));
        end
      end
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(bus.out_data), 32'(prev_d));
      end
      if (bus.done) begin
        if (prev_done) begin
          n_total++;
          $display("FAIL done_width: got 2+ cycles expected 1");
        end
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.in_ready) in_ready_seen = 1'b1;
      prev_v    = bus.out_valid;
      prev_r    = bus.out_ready;
      prev_d    = bus.out_data;
      prev_done = bus.done;
    end else begin
      prev_v    = 1'b0;
      prev_done = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit last);
    exp_q.push_back({last, d});
  endtask

  task automatic make_body(input int unsigned cnt, input int unsigned base);
    body.delete();
    for (int unsigned i = 0; i < cnt; i++) body.push_back(8'(base + i * 3));
  endtask

  task automatic push_body();
    for (int unsigned i = 0; i < body.size(); i++) push(body[i], i == body.size() - 1);
  endtask

  task automatic do_start(input int unsigned len);
    bus.start   = 1'b1;
    bus.str_len = LEN_W'(len);
    tick();
    start_cyc   = cyc;
    bus.start   = 1'b0;
  endtask

  task automatic feed(input int unsigned cnt, input bit gaps);
    int unsigned bound;
    for (int unsigned i = 0; i < cnt; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = body[i];
      bound = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        bound++;
        if (bound > 500) begin
          n_total++;
          $display("FAIL feed_timeout: got no in_ready expected accept of byte %0d", i);
          break;
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned c0;
    c0 = done_cnt;
    for (int unsigned k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done_cnt != c0) return;
    end
    n_total++;
    $display("FAIL done_timeout: got no done expected done");
  endtask

  task automatic finish_test(input string name);
    tick();
    tick();
    @(negedge clk);
    check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({name, "_out_last"}, 32'(bus.out_last), 32'd0);
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int unsigned c;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.str_len   = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // L=0: header only, last on the value byte, in_ready stays low
    in_ready_seen = 1'b0;
    push(8'h01, 1'b0);
    push(8'h00, 1'b1);
    c = done_cnt;
    do_start(0);
    wait_done();
    check("l0_done_count", done_cnt - c, 32'd1);
    check("l0_in_ready_seen", 32'(in_ready_seen), 32'd0);
    finish_test("l0");

    // L=3 "abc"; done is high in the cycle ending 2+n+L = 6 edges after start
    push(8'h01, 1'b0);
    push(8'h18, 1'b0);
    push(8'h61, 1'b0);
    push(8'h62, 1'b0);
    push(8'h63, 1'b1);
    body.delete();
    body.push_back(8'h61);
    body.push_back(8'h62);
    body.push_back(8'h63);
    c = done_cnt;
    do_start(3);
    feed(3, 1'b0);
    wait_done();
    check("l3_done_count", done_cnt - c, 32'd1);
    check("l3_start_to_done", done_cyc - start_cyc, 32'd5);
    finish_test("l3");

    // L=32: two-byte length
    push(8'h02, 1'b0);
    push(8'h01, 1'b0);
    push(8'h00, 1'b0);
    make_body(32, 8'h10);
    push_body();
    do_start(32);
    feed(32, 1'b0);
    wait_done();
    finish_test("l32");

    // L=MAX_LEN
    push(8'h02, 1'b0);
    push(8'h08, 1'b0);
    push(8'h00, 1'b0);
    make_body(256, 8'h07);
    push_body();
    do_start(256);
    feed(256, 1'b0);
    wait_done();
    finish_test("l256");

    // L=17 without and with stalls: identical expected stream
    for (int unsigned pass = 0; pass < 2; pass++) begin
      stall_mode = (pass == 1);
      push(8'h01, 1'b0);
      push(8'h88, 1'b0);
      make_body(17, 8'h40);
      push_body();
      c = done_cnt;
      do_start(17);
      feed(17, stall_mode);
      wait_done();
      stall_mode    = 1'b0;
      bus.out_ready = 1'b1;
      check("l17_done_count", done_cnt - c, 32'd1);
      finish_test("l17");
    end

    // start pulsed during HDR_VAL and during BODY is ignored
    push(8'h01, 1'b0);
    push(8'h20, 1'b0);
    make_body(4, 8'hC0);
    push_body();
    c = done_cnt;
    do_start(4);
    fork
      feed(4, 1'b0);
      begin
        tick();
        bus.start   = 1'b1;
        bus.str_len = LEN_W'(9);
        tick();
        bus.start   = 1'b0;
        tick();
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
      end
    join
    wait_done();
    repeat (4) tick();
    check("ign_done_count", done_cnt - c, 32'd1);
    finish_test("ign");

    // reset in BODY after 5 of 10 bytes
    push(8'h01, 1'b0);
    push(8'h50, 1'b0);
    make_body(10, 8'h33);
    push_body();
    c = done_cnt;
    do_start(10);
    feed(5, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_outputs_zero("midrst");
    check("midrst_abandoned", exp_q.size(), 32'd5);
    exp_q.delete();
    rst = 1'b0;
    tick();
    tick();
    check("midrst_no_done", done_cnt - c, 32'd0);

    // fresh L=1 after reset
    push(8'h01, 1'b0);
    push(8'h08, 1'b0);
    push(8'hA5, 1'b1);
    body.delete();
    body.push_back(8'hA5);
    c = done_cnt;
    do_start(1);
    feed(1, 1'b0);
    wait_done();
    check("l1_done_count", done_cnt - c, 32'd1);
    finish_test("l1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
